// File: rtl/gate_eval_sched.sv
// Round-robin arbiter sharing one NOT/AND/OR/XOR evaluator among N_REQ requesters.
// One request in flight: IDLE grants, EVAL counts EVAL_LAT cycles, RESP holds the tagged result.
module gate_eval_sched #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int EVAL_LAT = 2,
  parameter int ID_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [2*N_REQ-1:0]      req_op,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);
  localparam int CNT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  state_t                state, state_nx;
  logic [ID_W-1:0]       rr_ptr, id_q, gnt_id;
  logic [CNT_W-1:0]      cnt;
  req_t                  cap_q;
  req_t [N_REQ-1:0]      lane;
  logic [DATA_W-1:0]     res_q, res_d;
  logic                  gnt_vld;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = {req_op[2*i +: 2], req_a[DATA_W*i +: DATA_W], req_b[DATA_W*i +: DATA_W]};
  end

  // First valid requester at or after rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    logic [ID_W:0] s;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    s       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      s = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (s >= (ID_W+1)'(N_REQ)) s = s - (ID_W+1)'(N_REQ);
      if (!gnt_vld && req_valid[s[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = s[ID_W-1:0];
      end
    end
  end

  always_comb begin
    res_d = '0;
    case (cap_q.op)
      2'b00:   res_d = ~cap_q.a;
      2'b01:   res_d = cap_q.a & cap_q.b;
      2'b10:   res_d = cap_q.a | cap_q.b;
      default: res_d = cap_q.a ^ cap_q.b;
    endcase
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: if (gnt_vld) begin
        req_ready[gnt_id] = rst_n;
        state_nx          = EVAL;
      end
      EVAL:    if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      cap_q  <= '0;
      id_q   <= '0;
      res_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (gnt_vld) begin
          cap_q  <= lane[gnt_id];
          id_q   <= gnt_id;
          rr_ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
          cnt    <= CNT_W'(EVAL_LAT-1);
        end
        EVAL: if (cnt == '0) res_q <= res_d;
              else           cnt   <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;
  assign rsp_data  = res_q;
endmodule

// File: tb/tb_gate_eval_sched.sv
// Directed bench for gate_eval_sched: round-robin model predicts each grant,
// expected responses are queued at grant time and popped when rsp_valid rises.
module tb_gate_eval_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } rsp_t;

  rsp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   m_rr  = 0;

  gate_eval_sched #(.N_REQ(4), .DATA_W(8), .EVAL_LAT(2), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  // Called at a negedge with inputs driven and the DUT idle; the accept edge follows.
  task automatic grant_step(input string tag);
    int   w;
    rsp_t e;
    w = -1;
    #1;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (m_rr + i) % 4;
      if (w < 0 && req_valid[j]) w = j;
    end
    if (w < 0) w = 0;
    chk({tag, "/ready"}, 32'(req_ready), 32'(1 << w));
    e.id   = 2'(w);
    e.data = f(req_op[2*w +: 2], req_a[8*w +: 8], req_b[8*w +: 8]);
    sbq.push_back(e);
    m_rr = (w + 1) % 4;
  endtask

  // Called at the first negedge after the accept edge.
  task automatic expect_rsp(input string tag, input int hold);
    int   waited;
    rsp_t e;
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (!rsp_valid) return;
    chk({tag, "/latency"}, 32'(waited), 32'd2);
    chk({tag, "/sbq_nonempty"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    chk({tag, "/rsp_id"}, 32'(rsp_id), 32'(e.id));
    chk({tag, "/rsp_data"}, 32'(rsp_data), 32'(e.data));
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "/hold_id"}, 32'(rsp_id), 32'(e.id));
      chk({tag, "/hold_data"}, 32'(rsp_data), 32'(e.data));
      chk({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk({tag, "/no_accept_in_resp"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "/rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle/ready", 32'(req_ready), 32'd0);
    chk("idle/busy", 32'(busy), 32'd0);

    // Single AND request from lane 0
    set_lane(0, 2'b01, 8'hF0, 8'h3C);
    req_valid = 4'b0001;
    grant_step("single");
    @(negedge clk);
    req_valid = '0;
    chk("single/busy", 32'(busy), 32'd1);
    chk("single/ready_once", 32'(req_ready), 32'd0);
    expect_rsp("single", 0);

    // Reset during EVAL drops the request and rewinds the pointer
    set_lane(2, 2'b11, 8'h5A, 8'h0F);
    req_valid = 4'b0100;
    #1;
    chk("rstmid/ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid/busy", 32'(busy), 32'd0);
    chk("rstmid/req_ready", 32'(req_ready), 32'd0);
    chk("rstmid/rsp_id", 32'(rsp_id), 32'd0);
    chk("rstmid/rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    m_rr = 0;
    repeat (5) begin
      @(negedge clk);
      chk("rstmid/no_rsp", 32'(rsp_valid), 32'd0);
    end

    // All four requesting continuously
    set_lane(0, 2'b00, 8'hAA, 8'h0F);
    set_lane(1, 2'b01, 8'hAA, 8'h0F);
    set_lane(2, 2'b10, 8'hAA, 8'h0F);
    set_lane(3, 2'b11, 8'hAA, 8'h0F);
    req_valid = 4'b1111;
    repeat (5) begin
      grant_step("rr4");
      @(negedge clk);
      expect_rsp("rr4", 0);
    end

    // Backpressure held for five cycles
    grant_step("bp");
    @(negedge clk);
    expect_rsp("bp", 5);

    // Pointer wrap
    req_valid = 4'b0100;
    grant_step("wrap_g2");
    @(negedge clk);
    expect_rsp("wrap_g2", 0);
    req_valid = 4'b0101;
    grant_step("wrap_g0");
    @(negedge clk);
    expect_rsp("wrap_g0", 0);
    req_valid = 4'b0011;
    grant_step("wrap_ptr1");
    @(negedge clk);
    req_valid = '0;
    expect_rsp("wrap_ptr1", 0);

    // Operand change during EVAL is ignored
    set_lane(0, 2'b00, 8'h11, 8'h00);
    req_valid = 4'b0001;
    grant_step("opchg");
    @(negedge clk);
    req_valid = '0;
    req_a[7:0] = 8'hFF;
    expect_rsp("opchg", 0);

    chk("end/sbq_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
